// File: rtl/option_pkg.sv
// Shared definitions for packed Option<T> values: one tag bit above the payload,
// tag 0 = Some, tag 1 = None.
package option_pkg;

    localparam logic TAG_SOME = 1'b0;
    localparam logic TAG_NONE = 1'b1;

    // Widest Option handled by none_word(); callers truncate to their own width.
    localparam int unsigned OPTION_MAX_W = 64;

    // Width of a packed Option carrying a w-bit payload.
    function automatic int unsigned option_w(input int unsigned w);
        return w + 1;
    endfunction

    // None literal for a packed Option of total width w: tag set, everything else zero.
    function automatic logic [OPTION_MAX_W-1:0] none_word(input int unsigned w);
        return {{(OPTION_MAX_W-1){1'b0}}, TAG_NONE} << (w - 1);
    endfunction

endpackage

// File: rtl/option_rr_arbiter_rr_pick.sv
// Purely combinational rotate-priority picker: returns the first valid bit
// found walking cyclically upward from ptr_i.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N_REQ-1:0] onehot_o
);

    logic [IDX_W-1:0] cand;

    // Scan offsets 0..N_REQ-1 from the pointer; IDX_W-bit truncation gives the modulo wrap.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'(ptr_i + k);
            if (!found_o && valid_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

    // Decode the winning index into a one-hot vector, empty when nothing is valid.
    always_comb begin
        onehot_o = '0;
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/option_rr_arbiter.sv
// Round-robin arbiter sharing one registered Option<(idx, payload)> output
// between N_REQ Option<uint<W>> producers, with downstream backpressure.
module option_rr_arbiter
    import option_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                         _i_clk,
    input  logic                         _i_rst,
    input  logic [N_REQ*option_w(W)-1:0] _i_req,
    input  logic                         _i_ready,
    output logic [N_REQ-1:0]             _o_grant,
    output logic [IDX_W+W:0]             __output
);

    localparam int unsigned OPT_W = option_w(W);
    localparam int unsigned OUT_W = 1 + IDX_W + W;

    typedef struct packed {
        logic             tag;
        logic [IDX_W-1:0] idx;
        logic [W-1:0]     payload;
    } out_t;

    localparam out_t OUT_NONE = out_t'(OUT_W'(none_word(OUT_W)));

    out_t             out_q, out_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] req_valid;
    logic [W-1:0]     req_payload [N_REQ];

    logic             out_empty;
    logic             load;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    // Split the packed request bus into per-requester Some flags and payloads.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_valid[i]   = (_i_req[i*OPT_W + W] == TAG_SOME);
            req_payload[i] = _i_req[i*OPT_W +: W];
        end
    end

    assign out_empty = (out_q.tag == TAG_NONE);
    assign load      = out_empty | _i_ready;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i  (req_valid),
        .ptr_i    (ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // Grant gating and next output/pointer: load on empty or consume, hold otherwise.
    always_comb begin
        _o_grant = '0;
        out_d    = out_q;
        ptr_d    = ptr_q;
        if (!_i_rst && load) begin
            if (pick_found) begin
                _o_grant      = pick_onehot;
                out_d.tag     = TAG_SOME;
                out_d.idx     = pick_idx;
                out_d.payload = req_payload[pick_idx];
                ptr_d         = pick_idx + IDX_W'(1);
            end else begin
                out_d = OUT_NONE;
            end
        end
    end

    // State registers; reset discards any held item and rewinds the pointer.
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            out_q <= OUT_NONE;
            ptr_q <= '0;
        end else begin
            out_q <= out_d;
            ptr_q <= ptr_d;
        end
    end

    assign __output = out_q;

endmodule

// File: tb/tb_option_rr_arbiter.sv
// Self-checking bench for option_rr_arbiter: directed steps from the test plan
// followed by constrained-random traffic against a behavioural model.
module tb_option_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int OW = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic [N*(W+1)-1:0] req;
    logic [N-1:0]      grant;
    logic [OW-1:0]     dout;

    always #5 clk = ~clk;

    option_rr_arbiter #(
        .N_REQ (N),
        .W     (W)
    ) dut (
        ._i_clk   (clk),
        ._i_rst   (rst),
        ._i_req   (req),
        ._i_ready (ready),
        ._o_grant (grant),
        .__output (dout)
    );

    int total = 0;
    int bad   = 0;

    // Requester drive state
    bit          r_some [N];
    logic [W-1:0] r_pay [N];

    // Reference model state
    bit m_full;
    int m_idx;
    int m_pay;
    int m_ptr;
    int wait_loads [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] model_out();
        if (m_full) return {1'b0, 2'(m_idx), 16'(m_pay)};
        return 19'h40000;
    endfunction

    // Winner = Some requester with the smallest cyclic distance from the pointer.
    function automatic int model_pick();
        int winner = -1;
        int best   = N;
        for (int i = 0; i < N; i++) begin
            if (r_some[i]) begin
                int d = (i - m_ptr + N) % N;
                if (d < best) begin
                    best   = d;
                    winner = i;
                end
            end
        end
        return winner;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req[i*(W+1) +: W+1] = {~r_some[i], r_pay[i]};
        end
    endtask

    task automatic set_all(input bit some, input logic [W-1:0] base);
        for (int i = 0; i < N; i++) begin
            r_some[i] = some;
            r_pay[i]  = base + W'(i);
        end
    endtask

    // One clock: check the combinational grant, advance the model, check the registered output.
    task automatic cycle(output int g);
        bit ld;
        logic [N-1:0] eg;
        drive_req();
        #1;
        ld = !m_full || ready;
        g  = (rst || !ld) ? -1 : model_pick();
        eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check("grant", 32'(grant), 32'(eg));
        if (rst) begin
            m_full = 0;
            m_ptr  = 0;
            for (int i = 0; i < N; i++) wait_loads[i] = 0;
        end else if (ld) begin
            for (int i = 0; i < N; i++) begin
                if (r_some[i] && i != g) begin
                    wait_loads[i]++;
                    check("fair_wait", 32'(wait_loads[i] < N), 32'd1);
                end else begin
                    wait_loads[i] = 0;
                end
            end
            if (g >= 0) begin
                m_full = 1;
                m_idx  = g;
                m_pay  = int'(r_pay[g]);
                m_ptr  = (g + 1) % N;
            end else begin
                m_full = 0;
            end
        end
        @(posedge clk);
        #1;
        check("out", 32'(dout), 32'(model_out()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int fair_idx [5] = '{0, 1, 2, 3, 0};
        logic [OW-1:0] held;

        m_full = 0; m_idx = 0; m_pay = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) wait_loads[i] = 0;
        rst = 1'b1;
        ready = 1'b0;
        set_all(1'b1, 16'h00B0);
        drive_req();
        @(negedge clk);

        // Reset held two cycles with every requester Some
        repeat (2) begin
            cycle(g);
            check("rst_out", 32'(dout), 32'h40000);
        end

        // Single request from requester 2
        rst = 1'b0;
        ready = 1'b1;
        set_all(1'b0, 16'h1111);
        r_some[2] = 1'b1;
        r_pay[2]  = 16'd123;
        cycle(g);
        check("single_idx", 32'(g), 32'd2);
        check("single_out", 32'(dout), 32'({1'b0, 2'd2, 16'd123}));

        // Rewind the pointer, then all four Some for five loads
        rst = 1'b1;
        cycle(g);
        rst = 1'b0;
        set_all(1'b1, 16'h00A0);
        for (int k = 0; k < 5; k++) begin
            cycle(g);
            check("fair_idx", 32'(dout[17:16]), 32'(fair_idx[k]));
            check("fair_pay", 32'(dout[15:0]), 32'(16'h00A0 + 16'(fair_idx[k])));
        end

        // Backpressure: fill with idx 1, then stall with requester 3 pending
        set_all(1'b0, 16'h0000);
        r_some[1] = 1'b1;
        r_pay[1]  = 16'h5151;
        cycle(g);
        check("bp_fill_idx", 32'(dout[17:16]), 32'd1);
        held = dout;
        r_some[1] = 1'b0;
        r_some[3] = 1'b1;
        r_pay[3]  = 16'h7373;
        ready = 1'b0;
        repeat (3) begin
            cycle(g);
            check("bp_hold", 32'(dout), 32'(held));
        end
        ready = 1'b1;
        cycle(g);
        check("bp_release_idx", 32'(dout[17:16]), 32'd3);

        // Drain to None, then an all-Some pick confirms the pointer stayed put
        r_some[3] = 1'b0;
        cycle(g);
        check("drain_out", 32'(dout), 32'h40000);
        set_all(1'b1, 16'h00C0);
        cycle(g);
        check("drain_ptr0", 32'(dout[17:16]), 32'd0);
        set_all(1'b0, 16'h0000);
        cycle(g);
        check("drain2_out", 32'(dout), 32'h40000);
        set_all(1'b1, 16'h00D0);
        cycle(g);
        check("drain_ptr1", 32'(dout[17:16]), 32'd1);

        // Reset mid-stream discards the held item
        rst = 1'b1;
        cycle(g);
        check("mid_rst_out", 32'(dout), 32'h40000);
        rst = 1'b0;
        cycle(g);
        check("post_rst_idx", 32'(dout[17:16]), 32'd0);

        // Random traffic honouring the hold-until-granted contract
        for (int k = 0; k < 400; k++) begin
            ready = ($urandom_range(0, 9) < 7);
            rst   = ($urandom_range(0, 63) == 0);
            cycle(g);
            for (int i = 0; i < N; i++) begin
                if (!r_some[i] || i == g) begin
                    r_some[i] = ($urandom_range(0, 2) == 0);
                    r_pay[i]  = W'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/option_rr_arbiter.md
# option_rr_arbiter

Round-robin arbiter that shares one downstream consumer between `N_REQ` producers, each presenting a packed `Option<uint<W>>`. On each load it picks one `Some` requester and forwards the payload with the requester index as a registered `Option<(idx, payload)>`. It accepts downstream backpressure. It sits between the per-lane Option-producing pipelines and a single shared sink.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (power of two, ≥2).
- `W`, 16, payload width.
- `IDX_W`, clog2(`N_REQ`) = 2, derived; requester index width.

Ports:
- `_i_clk`  in  1  clock; all state updates on rising edge.
- `_i_rst`  in  1  reset, synchronous, active-high.
- `_i_req`  in  `N_REQ*(W+1)`  packed Options. Requester i is in bits `[i*(W+1) +: W+1]`. MSB of each slice is the tag: 0 = Some, 1 = None. Low W bits are the payload.
- `_i_ready`  in  1  downstream consumes the current `__output` this cycle.
- `_o_grant`  out  `N_REQ`  one-hot, combinational. Bit i = 1 means requester i's Some is consumed this cycle.
- `__output`  out  `1+IDX_W+W`  registered Option. Layout is {tag, idx, payload}: tag 0 = Some, tag 1 = None.

## Operation
- State:
  - Output register `out_q` (1+IDX_W+W bits).
  - Round-robin pointer `ptr` (IDX_W bits).
- Reset values:
  - `out_q` = {1, 0…0}, i.e. None with zero idx and payload (19'h40000 at defaults).
  - `ptr` = 0.
  - `_o_grant` = 0 while `_i_rst` = 1.
- Empty is `out_q` tag = 1. Full is tag = 0.
- Load condition: `load` = empty OR `_i_ready`.
- Pick: find the first i in cyclic order `ptr`, `ptr`+1, …, `ptr`+N_REQ−1 (mod N_REQ) whose request tag = 0.
- When `load` = 1 and a pick exists:
  - `_o_grant[i]` = 1.
  - `out_q` ← {0, i, payload_i}.
  - `ptr` ← (i+1) mod N_REQ, wrapping naturally in IDX_W bits.
- When `load` = 1 and no requester is Some:
  - `_o_grant` = 0.
  - `out_q` ← {1, 0, 0}; None always carries zero idx and payload.
  - `ptr` unchanged.
- When `load` = 0 (full and not ready): `_o_grant` = 0; `out_q` and `ptr` hold.
- `_i_ready` while empty is legal and has no effect beyond the normal load.
- Requester contract: once Some is presented, it stays stable until its grant bit is seen. The arbiter does not latch ungranted requests.
- Fairness: a requester holding Some continuously is granted within N_REQ loads.
- Reset mid-operation: a held Some in `out_q` is discarded, not delivered. No grant is issued in the reset cycle.

## Timing
- Latency: a grant in cycle t makes `__output` = Some in cycle t+1.
- Throughput: one item per cycle while `_i_ready` = 1 and requests are present.
- Consume and refill happen in the same cycle: `_i_ready` = 1 with a full output consumes the current item and loads the next one (or None) in the same edge.
- `_o_grant` is a combinational function of `_i_req`, `ptr`, `out_q` tag, `_i_ready` and `_i_rst`. There is no combinational path from `_i_req` to `__output`.

## Structure
- Shared package `option_pkg`:
  - Constants `TAG_SOME` = 1'b0 and `TAG_NONE` = 1'b1.
  - Function `option_w(w)` = w+1.
  - Helper to build the None literal.
- Sub-module `rr_pick`: purely combinational rotate-priority picker.
  - Inputs: `N_REQ`-bit valid vector, `ptr`.
  - Outputs: `found`, `idx`, one-hot.
  - Implementation: double-width vector trick or rotate/priority/unrotate.
- Top level holds `out_q`, `ptr`, load logic and grant gating.

## Test plan
- Reset: hold `_i_rst` 2 cycles with all requests Some.
  - Expect `__output` = 19'h40000.
  - Expect `_o_grant` = 0 throughout.
- Single request: requester 2 = Some(16'd123), others None, `_i_ready` = 1.
  - Expect `_o_grant` = 4'b0100.
  - Next cycle expect `__output` = {1'b0, 2'd2, 16'd123}.
- Fairness: all four Some with payloads 0xA0..0xA3, `_i_ready` = 1 for 5 cycles.
  - Expect grants 0001, 0010, 0100, 1000, 0001.
  - Expect `__output` idx sequence 0, 1, 2, 3, 0.
- Backpressure: output full with idx 1, `_i_ready` = 0 for 3 cycles, requester 3 Some.
  - Expect `__output` unchanged and `_o_grant` = 0.
  - On `_i_ready` = 1, expect grant 1000 and idx 3 next cycle.
- Drain: output full, all requests None, `_i_ready` = 1.
  - Next cycle expect `__output` = 19'h40000, with `ptr` unchanged (verified by a subsequent all-Some pick).
- Reset mid-stream: output full with Some, assert `_i_rst` one cycle.
  - Expect `__output` = None and grant 0.
  - After release, with all Some, expect the first grant = 0001.
